// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module : iir_pkg
// Brief  : Shared widths and sizing constants for the IIR datapath blocks.
// Rev    : 1.0
// ============================================================================
package iir_pkg;

    localparam int DATA_W         = 12;
    localparam int OUT_FIFO_DEPTH = 8;
    localparam int OUT_FIFO_AF    = 6;

endpackage : iir_pkg
`default_nettype wire

// File: rtl/iir_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : iir_fifo_mem
// Brief  : DEPTH x DW register file, one synchronous write, one async read.
// Rev    : 1.0
// ============================================================================
module iir_fifo_mem #(
    parameter int DW    = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Contents are deliberately left unreset; occupancy tracking guards reads.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : iir_fifo_mem
`default_nettype wire

// File: rtl/iir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module : iir_out_fifo
// Brief  : FWFT elastic buffer behind the IIR filter, drops on full with
//          a sticky overflow flag.
// Rev    : 1.0
// ============================================================================
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int DW       = DATA_W,
    parameter int DEPTH    = OUT_FIFO_DEPTH,
    parameter int AF_LEVEL = OUT_FIFO_AF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DW-1:0]          DIN,
    input  logic                   VIN,
    output logic [DW-1:0]          DOUT,
    output logic                   VOUT,
    input  logic                   READY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   ALMOST_FULL,
    output logic                   OVF,
    input  logic                   CLR_OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_DEPTH    = DEPTH[CW-1:0];
    localparam logic [CW-1:0] c_AF_LEVEL = AF_LEVEL[CW-1:0];
    localparam logic [CW-1:0] c_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_af;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic [DW-1:0] w_rdata;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    // READY only matters while a sample is presented, so X on READY is harmless.
    assign w_pop   = !w_empty && READY;
    assign w_push  = VIN && (!w_full || w_pop);
    assign w_drop  = VIN && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_af    <= (w_count_nxt >= c_AF_LEVEL);
            if (CLR_OVF) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    iir_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (CLK),
        .i_we    (w_push),
        .i_waddr (r_wp),
        .i_wdata (DIN),
        .i_raddr (r_rp),
        .o_rdata (w_rdata)
    );

    assign VOUT        = !w_empty;
    assign DOUT        = w_empty ? '0 : w_rdata;
    assign COUNT       = r_count;
    assign ALMOST_FULL = r_af;
    assign OVF         = r_ovf;

endmodule : iir_out_fifo
`default_nettype wire
